ping_sequencer: RTL and testbench
=================================

# ping_sequencer

Sequences one sonar measurement ("ping"): on a start request it drives a fixed-length square-wave burst to the ultrasonic transmitter. It then blanks the receiver while the transducer rings down, and listens for the echo's rising edge. It reports the time-of-flight (in clk cycles, measured from burst start) over a valid/ready handshake. It sits between the system controller and the transducer driver / echo comparator, and replaces the free-running tone divider for transmit.

## Interface
Parameters:
- CLK_DIV, 10: tx_wave toggles every CLK_DIV+1 clk cycles (half-period).
- BURST_CYCLES, 8: full tx_wave periods per burst; ≥1.
- BLANK_CLKS, 1000: clk cycles of ignored echo after the burst; ≥1.
- LISTEN_CLKS, 100000: clk cycles of echo window; ≥1.
- TOF_W, 32: tof width; must hold BURST_LEN+BLANK_CLKS+LISTEN_CLKS, where BURST_LEN = 2·BURST_CYCLES·(CLK_DIV+1).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset. Synchronous, active-low.
- start  in  1  request a ping; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- tx_en  out  1  high exactly during BURST.
- tx_wave  out  1  transmit square wave; 0 outside BURST.
- echo  in  1  asynchronous comparator output.
- tof  out  TOF_W  time-of-flight result; stable while tof_valid.
- timeout  out  1  qualifies tof: no echo within window; stable while tof_valid.
- tof_valid  out  1  result available.
- tof_ready  in  1  consumer accepts result.

## Operation
- States: IDLE, BURST, BLANK, LISTEN, REPORT.
- IDLE:
  - start=1 → BURST.
  - Clear the tof counter to 0 and the divider to 0.
  - Set tx_wave=1.
- BURST:
  - tx_wave starts high and toggles every CLK_DIV+1 cycles.
  - The state lasts exactly BURST_LEN cycles, then → BLANK with tx_wave=0.
- BLANK: lasts BLANK_CLKS cycles; echo edges are ignored; → LISTEN.
- LISTEN:
  - On a detected rising edge of synchronized echo: latch tof = current counter value, timeout=0, → REPORT.
  - After LISTEN_CLKS cycles with no edge: latch tof = BURST_LEN+BLANK_CLKS+LISTEN_CLKS, timeout=1, → REPORT.
  - An edge in the final LISTEN cycle counts as an echo, not a timeout.
  - Echo already high at LISTEN entry is not an edge.
- REPORT:
  - tof_valid=1.
  - On tof_valid&tof_ready → IDLE; tof_valid drops the next cycle.
  - tof/timeout hold their values until the next ping's REPORT.
- The tof counter starts at 0 in the first BURST cycle and increments every cycle through LISTEN. It never wraps, by the TOF_W constraint.
- start outside IDLE is ignored and not queued.
- Echo path: 2-flop synchronizer plus a previous-value flop; edge = sync & ~prev.
  - Pin-to-detect latency is 2 cycles.
  - This latency is included in tof and not compensated.

## Timing
- Reset: rstn=0 at any edge, including mid-burst or in REPORT, puts the block in IDLE on that edge. All outputs go to 0: busy, tx_en, tx_wave, tof, timeout, tof_valid. Synchronizer flops also clear.
- start high at edge T (in IDLE) → busy, tx_en, tx_wave high after edge T.
- BURST occupies counter values 0..BURST_LEN-1.
- BLANK occupies counter values BURST_LEN..BURST_LEN+BLANK_CLKS-1.
- LISTEN occupies the following LISTEN_CLKS counter values.
- REPORT is entered the cycle after detection or timeout; tof_valid is registered.
- Minimum ping-to-ping spacing: one IDLE cycle after the handshake.

## Structure
- Shared package sonar_pkg: state enum (IDLE, BURST, BLANK, LISTEN, REPORT) and default timing constants, so system controllers and benches use the same values.
- Sub-module echo_sync: async-to-clk synchronizer with rising-edge pulse output and synchronous active-low reset. It is reused by future receive-side blocks.
- The divider and all counters stay inline in ping_sequencer.

## Test plan
Common parameters unless stated: CLK_DIV=1, BURST_CYCLES=2, BLANK_CLKS=4, LISTEN_CLKS=20, giving BURST_LEN=8.
- Burst shape: start pulse → tx_en high for 8 cycles; tx_wave=1,1,0,0,1,1,0,0; then tx_wave=0 and busy stays 1.
- Echo hit: echo rises at counter 13 and stays high → tof_valid with tof=15, timeout=0. Hold tof_ready=0 for 5 cycles → tof stable; then ready → IDLE.
- Blanking: echo pulses during counters 8..11 and stays high into LISTEN → timeout=1, tof=32.
- Timeout: echo held 0 → REPORT after counter 31 with tof=32, timeout=1. An echo edge detected exactly at counter 31 → tof=31, timeout=0.
- Start during busy: extra start pulses in BURST/LISTEN/REPORT → exactly one ping. start held high through the handshake → the next ping begins after one IDLE cycle.
- Reset mid-operation: rstn=0 at counter 5 → all outputs 0 next cycle. A new start runs a full ping with tof measured from 0.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared sonar definitions: sequencer state encoding and default ping timing,
// so controllers and benches agree on the same numbers.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BURST  = 3'd1,
    BLANK  = 3'd2,
    LISTEN = 3'd3,
    REPORT = 3'd4
  } ping_state_e;

  localparam int DEF_CLK_DIV      = 10;
  localparam int DEF_BURST_CYCLES = 8;
  localparam int DEF_BLANK_CLKS   = 1000;
  localparam int DEF_LISTEN_CLKS  = 100000;
  localparam int DEF_TOF_W        = 32;

  // Burst length in clk cycles: two half-periods of CLK_DIV+1 per wave period.
  function automatic int burst_len(input int clk_div, input int burst_cycles);
    return 2 * burst_cycles * (clk_div + 1);
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for an asynchronous comparator input with a
// single-cycle rising-edge pulse; pin-to-pulse latency is two clk cycles.
module echo_sync (
  input  logic clk,
  input  logic rstn,
  input  logic async_in,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_in};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/ping_sequencer.sv
// One sonar ping: square-wave burst, receiver blanking, echo listen window,
// and a time-of-flight result on a valid/ready handshake.
module ping_sequencer
  import sonar_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int BURST_CYCLES = DEF_BURST_CYCLES,
  parameter int BLANK_CLKS   = DEF_BLANK_CLKS,
  parameter int LISTEN_CLKS  = DEF_LISTEN_CLKS,
  parameter int TOF_W        = DEF_TOF_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  output logic             tx_en,
  output logic             tx_wave,
  input  logic             echo,
  output logic [TOF_W-1:0] tof,
  output logic             timeout,
  output logic             tof_valid,
  input  logic             tof_ready
);

  localparam int BURST_LEN = burst_len(CLK_DIV, BURST_CYCLES);
  localparam int TOTAL     = BURST_LEN + BLANK_CLKS + LISTEN_CLKS;
  localparam int DIV_W     = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;

  localparam logic [TOF_W-1:0] BURST_LAST  = TOF_W'(BURST_LEN - 1);
  localparam logic [TOF_W-1:0] BLANK_LAST  = TOF_W'(BURST_LEN + BLANK_CLKS - 1);
  localparam logic [TOF_W-1:0] LISTEN_LAST = TOF_W'(TOTAL - 1);
  localparam logic [TOF_W-1:0] TOF_MISS    = TOF_W'(TOTAL);
  localparam logic [DIV_W-1:0] DIV_MAX     = DIV_W'(CLK_DIV);

  ping_state_e      state;
  logic [TOF_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic             echo_rise;

  echo_sync u_echo_sync (
    .clk      (clk),
    .rstn     (rstn),
    .async_in (echo),
    .rise     (echo_rise)
  );

  assign busy  = (state != IDLE);
  assign tx_en = (state == BURST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      div       <= '0;
      tx_wave   <= 1'b0;
      tof       <= '0;
      timeout   <= 1'b0;
      tof_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          div <= '0;
          if (start) begin
            state   <= BURST;
            tx_wave <= 1'b1;
          end
        end
        BURST: begin
          cnt <= cnt + 1'b1;
          if (cnt == BURST_LAST) begin
            state   <= BLANK;
            tx_wave <= 1'b0;
          end else if (div == DIV_MAX) begin
            div     <= '0;
            tx_wave <= ~tx_wave;
          end else begin
            div <= div + 1'b1;
          end
        end
        BLANK: begin
          // Ringdown: edges seen here are dropped, the synchronizer keeps tracking.
          cnt <= cnt + 1'b1;
          if (cnt == BLANK_LAST) state <= LISTEN;
        end
        LISTEN: begin
          cnt <= cnt + 1'b1;
          if (echo_rise) begin
            state     <= REPORT;
            tof       <= cnt;
            timeout   <= 1'b0;
            tof_valid <= 1'b1;
          end else if (cnt == LISTEN_LAST) begin
            state     <= REPORT;
            tof       <= TOF_MISS;
            timeout   <= 1'b1;
            tof_valid <= 1'b1;
          end
        end
        REPORT: begin
          if (tof_ready) begin
            state     <= IDLE;
            tof_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ping_sequencer.sv
// Directed bench for ping_sequencer with a short ping (BURST_LEN=8, miss tof=32).
module tb_ping_sequencer;

  localparam int TOF_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic             echo = 1'b0;
  logic             tof_ready = 1'b0;
  logic             busy, tx_en, tx_wave, timeout, tof_valid;
  logic [TOF_W-1:0] tof;

  int n_tests = 0;
  int n_fail  = 0;

  ping_sequencer #(
    .CLK_DIV(1), .BURST_CYCLES(2), .BLANK_CLKS(4), .LISTEN_CLKS(20), .TOF_W(TOF_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .tx_en(tx_en),
    .tx_wave(tx_wave), .echo(echo), .tof(tof), .timeout(timeout),
    .tof_valid(tof_valid), .tof_ready(tof_ready)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs and samples change 1 ns after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench in the cycle whose counter value is 0.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns cycles waited until tof_valid, or -1 if it never came.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!tof_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    if (!tof_valid) cyc = -1;
  endtask

  task automatic handshake();
    tof_ready = 1'b1;
    tick();
    tof_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(2);
    n_tests++;
    if ({busy, tx_en, tx_wave, timeout, tof_valid} !== 5'b0 || tof !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b tx_en=%b tx_wave=%b timeout=%b valid=%b tof=%0d, want all 0",
               busy, tx_en, tx_wave, timeout, tof_valid, tof);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_burst_shape();
    logic [7:0] wave_exp;
    int cyc;
    wave_exp = 8'b11001100;
    do_start();
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (tx_en !== 1'b1 || busy !== 1'b1 || tx_wave !== wave_exp[7-i]) begin
        n_fail++;
        $display("FAIL burst_c%0d: tx_en=%b busy=%b tx_wave=%b, want 1 1 %b",
                 i, tx_en, busy, tx_wave, wave_exp[7-i]);
      end
      tick();
    end
    n_tests++;
    if (tx_en !== 1'b0 || tx_wave !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_end: tx_en=%b tx_wave=%b busy=%b, want 0 0 1", tx_en, tx_wave, busy);
    end
    wait_valid(cyc);
    n_tests++;
    if (cyc < 0) begin
      n_fail++;
      $display("FAIL burst_ping_done: tof_valid never rose, want 1");
    end
    handshake();
  endtask

  task automatic test_echo_hit();
    int cyc;
    logic [TOF_W-1:0] held;
    do_start();
    tick(13);
    echo = 1'b1;
    wait_valid(cyc);
    n_tests++;
    if (cyc != 3 || tof !== 15 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL echo_hit: wait=%0d tof=%0d timeout=%b, want wait=3 tof=15 timeout=0",
               cyc, tof, timeout);
    end
    held = 15;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (tof_valid !== 1'b1 || tof !== held || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL echo_hold_%0d: valid=%b tof=%0d timeout=%b, want 1 15 0",
                 i, tof_valid, tof, timeout);
      end
    end
    handshake();
    n_tests++;
    if (tof_valid !== 1'b0 || busy !== 1'b0 || tof !== held) begin
      n_fail++;
      $display("FAIL echo_accept: valid=%b busy=%b tof=%0d, want 0 0 15", tof_valid, busy, tof);
    end
    echo = 1'b0;
    tick(3);
  endtask

  task automatic test_blanking();
    int cyc;
    do_start();
    tick(8);
    echo = 1'b1;
    wait_valid(cyc);
    n_tests++;
    if (cyc < 0 || tof !== 32 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL blanking: wait=%0d tof=%0d timeout=%b, want tof=32 timeout=1", cyc, tof, timeout);
    end
    handshake();
    echo = 1'b0;
    tick(3);
  endtask

  task automatic test_timeout();
    int cyc;
    logic early;
    early = 1'b0;
    do_start();
    for (int i = 0; i < 32; i++) begin
      if (tof_valid) early = 1'b1;
      tick();
    end
    n_tests++;
    if (early || tof_valid !== 1'b1 || tof !== 32 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: early=%b valid=%b tof=%0d timeout=%b, want 0 1 32 1",
               early, tof_valid, tof, timeout);
    end
    handshake();
    tick();
    do_start();
    tick(29);
    echo = 1'b1;
    wait_valid(cyc);
    n_tests++;
    if (cyc != 3 || tof !== 31 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL last_listen_edge: wait=%0d tof=%0d timeout=%b, want wait=3 tof=31 timeout=0",
               cyc, tof, timeout);
    end
    handshake();
    echo = 1'b0;
    tick(3);
  endtask

  task automatic test_start_busy();
    int cyc;
    logic extra;
    extra = 1'b0;
    do_start();
    tick(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(11);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(cyc);
    n_tests++;
    if (cyc < 0 || tof !== 32 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_ping: wait=%0d tof=%0d timeout=%b, want tof=32 timeout=1", cyc, tof, timeout);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    handshake();
    for (int i = 0; i < 4; i++) begin
      if (busy) extra = 1'b1;
      tick();
    end
    n_tests++;
    if (extra) begin
      n_fail++;
      $display("FAIL busy_start_queued: busy=1 after handshake, want 0");
    end
    start = 1'b1;
    tick();
    wait_valid(cyc);
    handshake();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_start_gap: busy=%b in cycle after handshake, want 0", busy);
    end
    tick();
    n_tests++;
    if (busy !== 1'b1 || tx_en !== 1'b1 || tx_wave !== 1'b1) begin
      n_fail++;
      $display("FAIL held_start_restart: busy=%b tx_en=%b tx_wave=%b, want 1 1 1", busy, tx_en, tx_wave);
    end
    start = 1'b0;
    wait_valid(cyc);
    handshake();
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_start();
    tick(5);
    rstn = 1'b0;
    tick();
    n_tests++;
    if ({busy, tx_en, tx_wave, timeout, tof_valid} !== 5'b0 || tof !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b tx_en=%b tx_wave=%b timeout=%b valid=%b tof=%0d, want all 0",
               busy, tx_en, tx_wave, timeout, tof_valid, tof);
    end
    rstn = 1'b1;
    tick();
    do_start();
    tick(13);
    echo = 1'b1;
    wait_valid(cyc);
    n_tests++;
    if (cyc != 3 || tof !== 15 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_then_ping: wait=%0d tof=%0d timeout=%b, want wait=3 tof=15 timeout=0",
               cyc, tof, timeout);
    end
    handshake();
    echo = 1'b0;
    tick(2);
  endtask

  initial begin
    tick();
    test_reset();
    test_burst_shape();
    test_echo_hit();
    test_blanking();
    test_timeout();
    test_start_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
